// File: rtl/mshr_multi_pre_allocator.sv
// mshr_multi_pre_allocator: claims up to ALLOC_PORT_NUM free MSHR IDs per
// cycle into a circular buffer and serves them in order to miss consumers.
// Ports: clk, rst_n (async low); v_in_vld/v_in_rdy free-vector claim;
// flush/v_release hand buffered IDs back; out_vld/out_rdy/out_index
// per-port ID delivery (port 0 = oldest); buf_cnt registered occupancy.
module mshr_multi_pre_allocator #(
  parameter int ENTRY_NUM      = 16,
  parameter int ID_WIDTH       = $clog2(ENTRY_NUM),
  parameter int ALLOC_PORT_NUM = 2,
  parameter int BUF_DEPTH      = 4,
  parameter int CNT_WIDTH      = $clog2(BUF_DEPTH+1)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [ENTRY_NUM-1:0]               v_in_vld,
  output logic [ENTRY_NUM-1:0]               v_in_rdy,
  input  logic                               flush,
  output logic [ENTRY_NUM-1:0]               v_release,
  output logic [ALLOC_PORT_NUM-1:0]          out_vld,
  input  logic [ALLOC_PORT_NUM-1:0]          out_rdy,
  output logic [ALLOC_PORT_NUM*ID_WIDTH-1:0] out_index,
  output logic [CNT_WIDTH-1:0]               buf_cnt
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  logic [ID_WIDTH-1:0]  mem_q [BUF_DEPTH];
  logic [ID_WIDTH-1:0]  mem_d [BUF_DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  int cnt_i;
  int pop_n;
  int fill_n;
  int fill_max;
  int space;
  logic run;

  assign cnt_i   = int'(cnt_q);
  assign buf_cnt = cnt_q;

  // Output ports: port p shows the p-th oldest buffered ID.
  always_comb begin
    out_vld   = '0;
    out_index = '0;
    for (int p = 0; p < ALLOC_PORT_NUM; p++) begin
      out_vld[p] = !flush && (cnt_i > p);
      out_index[p*ID_WIDTH +: ID_WIDTH] =
        mem_q[PTR_W'((int'(rd_ptr_q) + p) % BUF_DEPTH)];
    end
  end

  // Only the leading run of accepting ports transfers.
  always_comb begin
    pop_n = 0;
    run   = 1'b1;
    for (int p = 0; p < ALLOC_PORT_NUM; p++) begin
      run = run & out_vld[p] & out_rdy[p];
      if (run) pop_n = pop_n + 1;
    end
  end

  // Claim from the registered free space only; pops this cycle
  // are not credited so the claim path stays short.
  always_comb begin
    space    = BUF_DEPTH - cnt_i;
    fill_max = 0;
    if (!flush)
      fill_max = (space < ALLOC_PORT_NUM) ? space : ALLOC_PORT_NUM;
    fill_n   = 0;
    v_in_rdy = '0;
    for (int b = 0; b < BUF_DEPTH; b++) mem_d[b] = mem_q[b];
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (v_in_vld[i] && (fill_n < fill_max)) begin
        v_in_rdy[i] = 1'b1;
        mem_d[PTR_W'((int'(wr_ptr_q) + fill_n) % BUF_DEPTH)] =
          ID_WIDTH'(i);
        fill_n = fill_n + 1;
      end
    end
  end

  always_comb begin
    v_release = '0;
    if (flush) begin
      for (int k = 0; k < BUF_DEPTH; k++) begin
        if (k < cnt_i)
          v_release[mem_q[PTR_W'((int'(rd_ptr_q) + k) % BUF_DEPTH)]] = 1'b1;
      end
    end
  end

  always_comb begin
    rd_ptr_d = PTR_W'((int'(rd_ptr_q) + pop_n) % BUF_DEPTH);
    wr_ptr_d = PTR_W'((int'(wr_ptr_q) + fill_n) % BUF_DEPTH);
    cnt_d    = CNT_WIDTH'(cnt_i - pop_n + fill_n);
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int b = 0; b < BUF_DEPTH; b++) mem_q[b] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      for (int b = 0; b < BUF_DEPTH; b++) mem_q[b] <= mem_d[b];
    end
  end

endmodule
